// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: holds decoded operands/control, applies stall/flush,
// resolves EX/MEM and MEM/WB forwarding and decodes the 4-bit ALU control code.
module id_ex_stage #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              stall_i,
   input  logic              flush_i,
   input  logic [DATA_W-1:0] rs1_data_i,
   input  logic [DATA_W-1:0] rs2_data_i,
   input  logic [DATA_W-1:0] imm_i,
   input  logic [REG_AW-1:0] rs1_addr_i,
   input  logic [REG_AW-1:0] rs2_addr_i,
   input  logic [REG_AW-1:0] rd_addr_i,
   input  logic [9:0]        funct_i,
   input  logic [1:0]        alu_op_i,
   input  logic              alu_src_i,
   input  logic              reg_write_i,
   input  logic              mem_to_reg_i,
   input  logic              mem_read_i,
   input  logic              mem_write_i,
   input  logic [REG_AW-1:0] exmem_rd_i,
   input  logic              exmem_reg_write_i,
   input  logic [DATA_W-1:0] exmem_result_i,
   input  logic [REG_AW-1:0] memwb_rd_i,
   input  logic              memwb_reg_write_i,
   input  logic [DATA_W-1:0] memwb_data_i,
   output logic [DATA_W-1:0] alu_data1_o,
   output logic [DATA_W-1:0] alu_data2_o,
   output logic [3:0]        alu_ctrl_o,
   output logic [DATA_W-1:0] store_data_o,
   output logic [REG_AW-1:0] rd_addr_o,
   output logic [REG_AW-1:0] rs1_addr_o,
   output logic [REG_AW-1:0] rs2_addr_o,
   output logic              reg_write_o,
   output logic              mem_to_reg_o,
   output logic              mem_read_o,
   output logic              mem_write_o,
   output logic              valid_o
);

   // valid_o high means the stage holds a real instruction. There is no
   // backpressure handshake: stall_i holds the contents, flush_i inserts a bubble.

   localparam logic [1:0] OP_MEM    = 2'b00;
   localparam logic [1:0] OP_BRANCH = 2'b01;
   localparam logic [1:0] OP_RTYPE  = 2'b10;
   localparam logic [1:0] OP_ITYPE  = 2'b11;

   localparam logic [9:0] F_ADD = 10'b0000000_000;
   localparam logic [9:0] F_SUB = 10'b0100000_000;
   localparam logic [9:0] F_MUL = 10'b0000001_000;
   localparam logic [9:0] F_AND = 10'b0000000_111;
   localparam logic [9:0] F_OR  = 10'b0000000_110;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_MUL = 4'b0111;

   logic [DATA_W-1:0] rs1_data_q;
   logic [DATA_W-1:0] rs2_data_q;
   logic [DATA_W-1:0] imm_q;
   logic [REG_AW-1:0] rs1_addr_q;
   logic [REG_AW-1:0] rs2_addr_q;
   logic [REG_AW-1:0] rd_addr_q;
   logic [9:0]        funct_q;
   logic [1:0]        alu_op_q;
   logic              alu_src_q;
   logic              reg_write_q;
   logic              mem_to_reg_q;
   logic              mem_read_q;
   logic              mem_write_q;
   logic              valid_q;

   // Flush outranks stall so a squashed instruction cannot linger in a held stage.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         rs1_data_q   <= '0;
         rs2_data_q   <= '0;
         imm_q        <= '0;
         rs1_addr_q   <= '0;
         rs2_addr_q   <= '0;
         rd_addr_q    <= '0;
         funct_q      <= '0;
         alu_op_q     <= '0;
         alu_src_q    <= 1'b0;
         reg_write_q  <= 1'b0;
         mem_to_reg_q <= 1'b0;
         mem_read_q   <= 1'b0;
         mem_write_q  <= 1'b0;
         valid_q      <= 1'b0;
      end else if (flush_i) begin
         rs1_data_q   <= '0;
         rs2_data_q   <= '0;
         imm_q        <= '0;
         rs1_addr_q   <= '0;
         rs2_addr_q   <= '0;
         rd_addr_q    <= '0;
         funct_q      <= '0;
         alu_op_q     <= '0;
         alu_src_q    <= 1'b0;
         reg_write_q  <= 1'b0;
         mem_to_reg_q <= 1'b0;
         mem_read_q   <= 1'b0;
         mem_write_q  <= 1'b0;
         valid_q      <= 1'b0;
      end else if (!stall_i) begin
         rs1_data_q   <= rs1_data_i;
         rs2_data_q   <= rs2_data_i;
         imm_q        <= imm_i;
         rs1_addr_q   <= rs1_addr_i;
         rs2_addr_q   <= rs2_addr_i;
         rd_addr_q    <= rd_addr_i;
         funct_q      <= funct_i;
         alu_op_q     <= alu_op_i;
         alu_src_q    <= alu_src_i;
         reg_write_q  <= reg_write_i;
         mem_to_reg_q <= mem_to_reg_i;
         mem_read_q   <= mem_read_i;
         mem_write_q  <= mem_write_i;
         valid_q      <= 1'b1;
      end
   end

   logic exmem_hit1, exmem_hit2, memwb_hit1, memwb_hit2;
   logic [DATA_W-1:0] fwd_rs1, fwd_rs2;

   // x0 is hard-wired zero, so a write "to x0" must never be forwarded.
   assign exmem_hit1 = exmem_reg_write_i && (exmem_rd_i != '0) && (exmem_rd_i == rs1_addr_q);
   assign exmem_hit2 = exmem_reg_write_i && (exmem_rd_i != '0) && (exmem_rd_i == rs2_addr_q);
   assign memwb_hit1 = memwb_reg_write_i && (memwb_rd_i != '0) && (memwb_rd_i == rs1_addr_q);
   assign memwb_hit2 = memwb_reg_write_i && (memwb_rd_i != '0) && (memwb_rd_i == rs2_addr_q);

   always_comb begin
      fwd_rs1 = rs1_data_q;
      if (exmem_hit1)
         fwd_rs1 = exmem_result_i;
      else if (memwb_hit1)
         fwd_rs1 = memwb_data_i;
   end

   always_comb begin
      fwd_rs2 = rs2_data_q;
      if (exmem_hit2)
         fwd_rs2 = exmem_result_i;
      else if (memwb_hit2)
         fwd_rs2 = memwb_data_i;
   end

   always_comb begin
      alu_ctrl_o = ALU_ADD;
      case (alu_op_q)
         OP_MEM:    alu_ctrl_o = ALU_ADD;
         OP_BRANCH: alu_ctrl_o = ALU_SUB;
         OP_ITYPE:  alu_ctrl_o = ALU_ADD;
         OP_RTYPE: begin
            case (funct_q)
               F_ADD:   alu_ctrl_o = ALU_ADD;
               F_SUB:   alu_ctrl_o = ALU_SUB;
               F_MUL:   alu_ctrl_o = ALU_MUL;
               F_AND:   alu_ctrl_o = ALU_AND;
               F_OR:    alu_ctrl_o = ALU_OR;
               default: alu_ctrl_o = ALU_ADD;
            endcase
         end
         default:   alu_ctrl_o = ALU_ADD;
      endcase
   end

   assign alu_data1_o  = fwd_rs1;
   assign store_data_o = fwd_rs2;
   assign alu_data2_o  = alu_src_q ? imm_q : fwd_rs2;

   assign rd_addr_o    = rd_addr_q;
   assign rs1_addr_o   = rs1_addr_q;
   assign rs2_addr_o   = rs2_addr_q;
   assign reg_write_o  = reg_write_q;
   assign mem_to_reg_o = mem_to_reg_q;
   assign mem_read_o   = mem_read_q;
   assign mem_write_o  = mem_write_q;
   assign valid_o      = valid_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed cases plus random traffic, scored against a
// reference model of the stage contents and forwarding rules.
module tb_id_ex_stage;

   localparam int DW = 32;
   localparam int AW = 5;

   logic          clk = 1'b0;
   logic          rst_i;
   logic          stall_i, flush_i;
   logic [DW-1:0] rs1_data_i, rs2_data_i, imm_i;
   logic [AW-1:0] rs1_addr_i, rs2_addr_i, rd_addr_i;
   logic [9:0]    funct_i;
   logic [1:0]    alu_op_i;
   logic          alu_src_i, reg_write_i, mem_to_reg_i, mem_read_i, mem_write_i;
   logic [AW-1:0] exmem_rd_i, memwb_rd_i;
   logic          exmem_reg_write_i, memwb_reg_write_i;
   logic [DW-1:0] exmem_result_i, memwb_data_i;
   logic [DW-1:0] alu_data1_o, alu_data2_o, store_data_o;
   logic [3:0]    alu_ctrl_o;
   logic [AW-1:0] rd_addr_o, rs1_addr_o, rs2_addr_o;
   logic          reg_write_o, mem_to_reg_o, mem_read_o, mem_write_o, valid_o;

   id_ex_stage #(.DATA_W(DW), .REG_AW(AW)) dut (
      .clk_i(clk), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
      .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .imm_i(imm_i),
      .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i), .rd_addr_i(rd_addr_i),
      .funct_i(funct_i), .alu_op_i(alu_op_i), .alu_src_i(alu_src_i),
      .reg_write_i(reg_write_i), .mem_to_reg_i(mem_to_reg_i),
      .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
      .exmem_rd_i(exmem_rd_i), .exmem_reg_write_i(exmem_reg_write_i),
      .exmem_result_i(exmem_result_i), .memwb_rd_i(memwb_rd_i),
      .memwb_reg_write_i(memwb_reg_write_i), .memwb_data_i(memwb_data_i),
      .alu_data1_o(alu_data1_o), .alu_data2_o(alu_data2_o), .alu_ctrl_o(alu_ctrl_o),
      .store_data_o(store_data_o), .rd_addr_o(rd_addr_o), .rs1_addr_o(rs1_addr_o),
      .rs2_addr_o(rs2_addr_o), .reg_write_o(reg_write_o), .mem_to_reg_o(mem_to_reg_o),
      .mem_read_o(mem_read_o), .mem_write_o(mem_write_o), .valid_o(valid_o)
   );

   // ---------------- clock / watchdog ----------------
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, required finish before 200000");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard ----------------
   typedef struct packed {
      logic [DW-1:0] d1, d2, st;
      logic [3:0]    ctrl;
      logic [AW-1:0] rd, a1, a2;
      logic          rw, m2r, mr, mw, v;
   } exp_t;

   exp_t exp_q[$];
   int   tests = 0;
   int   fails = 0;

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %h required %h at %0t", name, act, req, $time);
      end
   endtask

   // ---------------- reference model: contents of the stage ----------------
   logic [DW-1:0] m_rs1d, m_rs2d, m_imm;
   logic [AW-1:0] m_a1, m_a2, m_rd;
   logic [9:0]    m_funct;
   logic [1:0]    m_op;
   logic          m_src, m_rw, m_m2r, m_mr, m_mw, m_v;

   task automatic model_clear();
      m_rs1d = '0; m_rs2d = '0; m_imm = '0; m_a1 = '0; m_a2 = '0; m_rd = '0;
      m_funct = '0; m_op = '0; m_src = 0; m_rw = 0; m_m2r = 0; m_mr = 0; m_mw = 0; m_v = 0;
   endtask

   function automatic logic [3:0] ref_ctrl(input logic [1:0] op, input logic [9:0] f);
      if (op == 2'b01) return 4'b0110;
      if (op != 2'b10) return 4'b0010;
      if (f == 10'b0000000000) return 4'b0010;
      if (f == 10'b0100000000) return 4'b0110;
      if (f == 10'b0000001000) return 4'b0111;
      if (f == 10'b0000000111) return 4'b0000;
      if (f == 10'b0000000110) return 4'b0001;
      return 4'b0010;
   endfunction

   function automatic logic [DW-1:0] ref_fwd(input logic [AW-1:0] src, input logic [DW-1:0] regval);
      if (src == 0) return regval;
      if (exmem_reg_write_i && exmem_rd_i == src) return exmem_result_i;
      if (memwb_reg_write_i && memwb_rd_i == src) return memwb_data_i;
      return regval;
   endfunction

   task automatic push_exp();
      exp_t e;
      e.d1   = ref_fwd(m_a1, m_rs1d);
      e.st   = ref_fwd(m_a2, m_rs2d);
      e.d2   = m_src ? m_imm : e.st;
      e.ctrl = ref_ctrl(m_op, m_funct);
      e.rd = m_rd; e.a1 = m_a1; e.a2 = m_a2;
      e.rw = m_rw; e.m2r = m_m2r; e.mr = m_mr; e.mw = m_mw; e.v = m_v;
      exp_q.push_back(e);
   endtask

   // ---------------- monitor ----------------
   exp_t mon_e;
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         check("alu_data1", alu_data1_o, mon_e.d1);
         check("alu_data2", alu_data2_o, mon_e.d2);
         check("store_data", store_data_o, mon_e.st);
         check("alu_ctrl", {28'd0, alu_ctrl_o}, {28'd0, mon_e.ctrl});
         check("regs_ctrl",
               {10'd0, rd_addr_o, rs1_addr_o, rs2_addr_o, reg_write_o, mem_to_reg_o,
                mem_read_o, mem_write_o, valid_o},
               {10'd0, mon_e.rd, mon_e.a1, mon_e.a2, mon_e.rw, mon_e.m2r,
                mon_e.mr, mon_e.mw, mon_e.v});
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
      if (!rst_i || flush_i) model_clear();
      else if (!stall_i) begin
         m_rs1d = rs1_data_i; m_rs2d = rs2_data_i; m_imm = imm_i;
         m_a1 = rs1_addr_i; m_a2 = rs2_addr_i; m_rd = rd_addr_i;
         m_funct = funct_i; m_op = alu_op_i; m_src = alu_src_i;
         m_rw = reg_write_i; m_m2r = mem_to_reg_i; m_mr = mem_read_i;
         m_mw = mem_write_i; m_v = 1'b1;
      end
   endtask

   task automatic set_id(input logic [DW-1:0] d1, input logic [DW-1:0] d2, input logic [DW-1:0] imm,
                         input logic [AW-1:0] a1, input logic [AW-1:0] a2, input logic [AW-1:0] rd,
                         input logic [1:0] op, input logic [9:0] f, input logic src);
      rs1_data_i = d1; rs2_data_i = d2; imm_i = imm;
      rs1_addr_i = a1; rs2_addr_i = a2; rd_addr_i = rd;
      alu_op_i = op; funct_i = f; alu_src_i = src;
      reg_write_i = 1; mem_to_reg_i = 0; mem_read_i = 0; mem_write_i = src;
   endtask

   task automatic set_fwd(input logic exw, input logic [AW-1:0] exrd, input logic [DW-1:0] exres,
                          input logic wbw, input logic [AW-1:0] wbrd, input logic [DW-1:0] wbdat);
      exmem_reg_write_i = exw; exmem_rd_i = exrd; exmem_result_i = exres;
      memwb_reg_write_i = wbw; memwb_rd_i = wbrd; memwb_data_i = wbdat;
   endtask

   function automatic logic [AW-1:0] rand_addr();
      return ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 3));
   endfunction

   task automatic rand_id();
      logic [9:0] fl [6];
      fl = '{10'b0000000000, 10'b0100000000, 10'b0000001000, 10'b0000000111,
             10'b0000000110, 10'b0};
      fl[5] = 10'($urandom_range(0, 1023));
      rs1_data_i = $urandom; rs2_data_i = $urandom; imm_i = $urandom;
      rs1_addr_i = rand_addr(); rs2_addr_i = rand_addr(); rd_addr_i = rand_addr();
      funct_i = fl[$urandom_range(0, 5)];
      alu_op_i = 2'($urandom_range(0, 3));
      {alu_src_i, reg_write_i, mem_to_reg_i, mem_read_i, mem_write_i} = 5'($urandom_range(0, 31));
      stall_i = ($urandom_range(0, 4) == 0);
      flush_i = ($urandom_range(0, 9) == 0);
   endtask

   task automatic rand_fwd();
      set_fwd(1'($urandom_range(0, 1)), rand_addr(), $urandom,
              1'($urandom_range(0, 1)), rand_addr(), $urandom);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst_i = 0; stall_i = 0; flush_i = 0;
      set_id('0, '0, '0, '0, '0, '0, 2'b00, '0, 1'b0);
      reg_write_i = 0; mem_write_i = 0;
      set_fwd(0, '0, '0, 0, '0, '0);
      model_clear();
      #1;
      check("reset_valid", {31'd0, valid_o}, 32'd0);
      check("reset_ctrl", {28'd0, alu_ctrl_o}, 32'd2);
      check("reset_data1", alu_data1_o, 32'd0);
      @(negedge clk); rst_i = 1;

      // capture and decode: mul, sub, and
      set_id(5, 7, 0, 1, 2, 3, 2'b10, 10'b0000001000, 0);
      tick(); push_exp();
      set_id(5, 7, 0, 1, 2, 3, 2'b10, 10'b0100000000, 0);
      tick(); push_exp();
      set_id(5, 7, 0, 1, 2, 3, 2'b10, 10'b0000000111, 0);
      tick(); push_exp();

      // forward priority, then EX/MEM drops out while stalled
      set_id(1, 2, 0, 3, 6, 7, 2'b10, 10'b0, 0);
      tick(); set_fwd(1, 3, 32'hAA, 1, 3, 32'hBB); push_exp();
      stall_i = 1;
      tick(); set_fwd(0, 3, 32'hAA, 1, 3, 32'hBB); push_exp();
      stall_i = 0;

      // x0 never forwarded
      set_id(9, 0, 0, 1, 0, 4, 2'b00, 10'b0, 0);
      tick(); set_fwd(1, 0, 32'hFF, 1, 0, 32'hEE); push_exp();

      // immediate operand with forwarded store data
      set_id(9, 9, 16, 1, 4, 0, 2'b00, 10'b0, 1);
      tick(); set_fwd(0, 0, 0, 1, 4, 32'h1234); push_exp();

      // stall holds while ID changes, then stall+flush gives a bubble
      stall_i = 1;
      set_id(32'hDEAD, 32'hBEEF, 99, 8, 9, 10, 2'b01, 10'b0, 0);
      tick(); push_exp();
      flush_i = 1;
      tick(); push_exp();
      flush_i = 0; stall_i = 0;

      // asynchronous reset mid-cycle while stalled with nonzero contents
      set_id(32'h55, 32'h66, 3, 5, 6, 7, 2'b10, 10'b0000000110, 0);
      tick(); set_fwd(0, 0, 0, 0, 0, 0); push_exp();
      stall_i = 1;
      @(posedge clk); #2;
      rst_i = 0; #1;
      model_clear();
      check("async_valid", {31'd0, valid_o}, 32'd0);
      check("async_ctrl", {28'd0, alu_ctrl_o}, 32'd2);
      check("async_data1", alu_data1_o, 32'd0);
      check("async_rw_rd", {26'd0, reg_write_o, rd_addr_o}, 32'd0);
      @(negedge clk); rst_i = 1; stall_i = 0;
      tick(); push_exp();

      // random traffic
      for (int i = 0; i < 400; i++) begin
         rand_id();
         tick();
         rand_fwd();
         push_exp();
      end

      stall_i = 0; flush_i = 0;
      @(posedge clk); @(posedge clk);
      check("queue_drained", exp_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
